// File: rtl/program_sequencer.sv
// program_sequencer: instruction feeder for the cpu core.
// Holds a loadable program memory, drives the core's din/run inputs and steps a
// program counter. A 2-bit phase register mirrors the core's step counter so the
// instruction word is presented in fetch (phase 0) and an MVI immediate in phase 1.
// A HALT opcode drops run and waits for a new start.
// Optional feature: define SEQ_STEP_EN to add a single-step input (step_i); each
// step pulse allows exactly one RUN phase-0 fetch.
//
// state | meaning
// IDLE  | after reset, waiting for start; loads accepted
// ARM   | started, waiting for phase 3 so RUN begins on phase 0
// RUN   | feeding the core; fetch on phase 0
// HALT  | HALT word seen; loads accepted, start re-arms
module program_sequencer #(
    parameter int          ADDR_W  = 5,
    parameter int          DATA_W  = 16,
    parameter logic [2:0]  HALT_OP = 3'b111
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              load_en_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              cpu_done_i,
`ifdef SEQ_STEP_EN
    input  logic              step_i,
`endif
    output logic              cpu_run_o,
    output logic [DATA_W-1:0] cpu_din_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o,
    output logic              halted_o
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_HALT} state_t;

    localparam logic [2:0] OP_MVI      = 3'b001;
    localparam logic [2:0] OP_LAST_CLR = 3'b011;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        phase_q, phase_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] word;
    logic              is_halt;
    logic              fetch_ok;

    assign word     = mem_q[pc_q];
    assign is_halt  = (word[8:6] == HALT_OP);
    assign pc_o     = pc_q;
    assign busy_o   = (state_q == S_ARM) || (state_q == S_RUN);
    assign halted_o = (state_q == S_HALT);

`ifdef SEQ_STEP_EN
    logic step_pend_q, step_pend_d;

    // A fetch attempt on a HALT word does not spend the pending step.
    assign fetch_ok    = step_pend_q;
    assign step_pend_d = (step_pend_q &
                          ~((state_q == S_RUN) && (phase_q == 2'd0) && !is_halt)) | step_i;

    // Pending single-step flag.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            step_pend_q <= 1'b0;
        end else begin
            step_pend_q <= step_pend_d;
        end
    end
`else
    assign fetch_ok = 1'b1;
`endif

    // Program memory write port; not reset, writes only while not busy.
    always_ff @(posedge clk_i) begin
        if (load_en_i && !busy_o) begin
            mem_q[load_addr_i] <= load_data_i;
        end
    end

    // State, pc, phase mirror and latched opcode registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            phase_q <= 2'd0;
            op_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            phase_q <= phase_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic and core-facing outputs.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        op_d      = op_q;
        cpu_run_o = 1'b0;
        cpu_din_o = '0;
        // The core clears its counter on done only for opcodes 0..3; others wrap.
        if (cpu_done_i && (op_q <= OP_LAST_CLR)) begin
            phase_d = 2'd0;
        end else begin
            phase_d = phase_q + 2'd1;
        end

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start_i) begin
                    state_d = S_ARM;
                    pc_d    = '0;
                end
            end
            S_ARM: begin
                if (phase_q == 2'd3) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cpu_din_o = word;
                if (phase_q == 2'd0) begin
                    if (is_halt) begin
                        state_d = S_HALT;
                    end else if (fetch_ok) begin
                        cpu_run_o = 1'b1;
                        op_d      = word[8:6];
                        pc_d      = pc_q + ADDR_W'(1);
                    end
                end else begin
                    cpu_run_o = 1'b1;
                    // MVI immediate is consumed by the core in phase 1.
                    if ((phase_q == 2'd1) && (op_q == OP_MVI)) begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_program_sequencer.sv
`timescale 1ns/1ps
module tb_program_sequencer;
    localparam int AW = 5;
    localparam int DW = 16;
    localparam int NW = 32;
    localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_HALT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          cpu_done;
    logic          cpu_run;
    logic [DW-1:0] cpu_din;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
`ifdef SEQ_STEP_EN
    logic          step = 1'b1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    program_sequencer #(.ADDR_W(AW), .DATA_W(DW), .HALT_OP(3'b111)) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .start_i     (start),
        .load_en_i   (load_en),
        .load_addr_i (load_addr),
        .load_data_i (load_data),
        .cpu_done_i  (cpu_done),
`ifdef SEQ_STEP_EN
        .step_i      (step),
`endif
        .cpu_run_o   (cpu_run),
        .cpu_din_o   (cpu_din),
        .pc_o        (pc),
        .busy_o      (busy),
        .halted_o    (halted)
    );

    // ---------------- simple cpu core (environment) ----------------
    logic [1:0]    c_t = 2'd0;
    logic [8:0]    c_ir = 9'd0;
    logic [DW-1:0] c_r [8];
    logic [2:0]    c_op;
    logic          c_long;
    assign c_op     = c_ir[8:6];
    assign c_long   = (c_op == 3'd2) || (c_op == 3'd3);
    assign cpu_done = cpu_run && (c_long ? (c_t == 2'd3) : (c_t == 2'd1));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            c_t  <= 2'd0;
            c_ir <= 9'd0;
            for (int i = 0; i < 8; i++) c_r[i] <= '0;
        end else begin
            c_t <= (cpu_done && c_op <= 3'd3) ? 2'd0 : c_t + 2'd1;
            if (cpu_run) begin
                if (c_t == 2'd0) c_ir <= cpu_din[8:0];
                else if (c_t == 2'd1 && c_op == 3'd0) c_r[c_ir[5:3]] <= c_r[c_ir[2:0]];
                else if (c_t == 2'd1 && c_op == 3'd1) c_r[c_ir[5:3]] <= cpu_din;
                else if (c_t == 2'd3 && c_op == 3'd2) c_r[c_ir[5:3]] <= c_r[c_ir[5:3]] + c_r[c_ir[2:0]];
                else if (c_t == 2'd3 && c_op == 3'd3) c_r[c_ir[5:3]] <= c_r[c_ir[5:3]] - c_r[c_ir[2:0]];
            end
        end
    end

    // ---------------- behavioural reference model ----------------
    int            m_mode = M_IDLE;
    int            m_pc = 0, m_phase = 0, m_op = 0;
    bit            m_pend = 1'b0;
    logic [DW-1:0] m_mem [NW];
    logic [DW-1:0] mw;
    bit            m_busy_now, m_go, m_took;
    int            m_nphase;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_pc = 0; m_phase = 0; m_op = 0; m_pend = 1'b0;
        end else begin
            mw         = m_mem[m_pc];
            m_busy_now = (m_mode == M_ARM) || (m_mode == M_RUN);
`ifdef SEQ_STEP_EN
            m_go = m_pend;
`else
            m_go = 1'b1;
`endif
            m_took   = 1'b0;
            m_nphase = (cpu_done && m_op <= 3) ? 0 : (m_phase + 1) % 4;
            if (load_en && !m_busy_now) m_mem[load_addr] = load_data;
            if (m_mode == M_IDLE || m_mode == M_HALT) begin
                if (start) begin m_mode = M_ARM; m_pc = 0; end
            end else if (m_mode == M_ARM) begin
                if (m_phase == 3) m_mode = M_RUN;
            end else begin
                if (m_phase == 0) begin
                    if (mw[8:6] == 3'b111) m_mode = M_HALT;
                    else if (m_go) begin
                        m_op = int'(mw[8:6]); m_pc = (m_pc + 1) % NW; m_took = 1'b1;
                    end
                end else if (m_phase == 1 && m_op == 1) begin
                    m_pc = (m_pc + 1) % NW;
                end
            end
`ifdef SEQ_STEP_EN
            m_pend = (m_pend && !m_took) || step;
`endif
            m_phase = m_nphase;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting at %0t", nm, $time);
    endtask

    // Per-cycle compare of DUT outputs against the model.
    logic [DW-1:0] e_w;
    bit            e_run, e_go;
    always @(negedge clk) begin
        if (chk_en) begin
            e_w = m_mem[m_pc];
`ifdef SEQ_STEP_EN
            e_go = m_pend;
`else
            e_go = 1'b1;
`endif
            e_run = (m_mode == M_RUN) && (m_phase != 0 || (e_w[8:6] != 3'b111 && e_go));
            chk("cyc_pc", 32'(pc), 32'(m_pc));
            chk("cyc_busy", 32'(busy), 32'((m_mode == M_ARM) || (m_mode == M_RUN)));
            chk("cyc_halted", 32'(halted), 32'(m_mode == M_HALT));
            chk("cyc_run", 32'(cpu_run), 32'(e_run));
            if (m_mode != M_ARM)
                chk("cyc_din", 32'(cpu_din), (m_mode == M_RUN) ? 32'(e_w) : 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_run(input string nm);
        int i;
        for (i = 0; i < 12 && !cpu_run; i++) tick();
        if (!cpu_run) timeout(nm);
    endtask

    task automatic wait_halt(input string nm);
        int i;
        for (i = 0; i < 200 && !halted; i++) tick();
        if (!halted) timeout(nm);
    endtask

    // Run one two-word program (op word at 0, HALT at 1) and measure its timing.
    task automatic timing_run(input logic [DW-1:0] w, output int runs, output int pcs,
                              output int done_ph, output int after0, output int after1,
                              output int after2);
        int prev_pc, n_after;
        bit seen_done;
        do_reset();
        load(5'd0, w);
        load(5'd1, 16'h01C0);
        pulse_start();
        runs = 0; pcs = 0; done_ph = -1; after0 = -1; after1 = -1; after2 = -1;
        prev_pc = int'(pc); n_after = 0; seen_done = 1'b0;
        for (int i = 0; i < 30 && !halted; i++) begin
            if (seen_done && n_after < 3) begin
                if (n_after == 0) after0 = int'(c_t);
                else if (n_after == 1) after1 = int'(c_t);
                else after2 = int'(c_t);
                n_after++;
            end
            if (cpu_run) runs++;
            if (cpu_done && !seen_done) begin done_ph = int'(c_t); seen_done = 1'b1; end
            tick();
            if (int'(pc) != prev_pc && busy) pcs++;
            prev_pc = int'(pc);
        end
        if (!halted) timeout("timing_halt");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int runs, pcs, dph, a0, a1, a2;
        logic [DW-1:0] w;

        for (int i = 0; i < NW; i++) m_mem[i] = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        for (int a = 0; a < NW; a++) load(AW'(a), 16'h0000);
        chk("reset_idle_pc", 32'(pc), 32'd0);
        chk("reset_idle_busy", 32'(busy), 32'd0);

        // Demo program: MVI R0,5 ; MVI R1,3 ; ADD R0,R1 ; HALT
        load(5'd0, 16'h0040); load(5'd1, 16'h0005); load(5'd2, 16'h0048);
        load(5'd3, 16'h0003); load(5'd4, 16'h0081); load(5'd5, 16'h01C0);
        pulse_start();
        wait_run("prog_first_run");
        chk("prog_fetch_word", 32'(cpu_din), 32'h0040);
        tick();
        chk("prog_imm_word", 32'(cpu_din), 32'h0005);
        wait_halt("prog_halt");
        chk("prog_halted", 32'(halted), 32'd1);
        chk("prog_halt_pc", 32'(pc), 32'd5);
        chk("prog_r0", 32'(c_r[0]), 32'd8);
        chk("prog_r1", 32'(c_r[1]), 32'd3);

        // Reset in the middle of RUN.
        pulse_start();
        for (int i = 0; i < 20 && pc < 5'd2; i++) tick();
        rst = 1'b1;
        tick();
        chk("midrst_pc", 32'(pc), 32'd0);
        chk("midrst_run", 32'(cpu_run), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_halted", 32'(halted), 32'd0);
        chk("midrst_din", 32'(cpu_din), 32'd0);
        rst = 1'b0;

        // Start at each of the four phase offsets.
        for (int k = 0; k < 4; k++) begin
            do_reset();
            repeat (k) tick();
            pulse_start();
            wait_run("align_run");
            chk("align_phase0", 32'(c_t), 32'd0);
            chk("align_din", 32'(cpu_din), 32'h0040);
            tick();
            chk("align_ir", 32'(c_ir), 32'h040);
        end

        // ADD timing.
        timing_run(16'h0081, runs, pcs, dph, a0, a1, a2);
        chk("add_run_cycles", 32'(runs), 32'd4);
        chk("add_pc_steps", 32'(pcs), 32'd1);
        chk("add_done_phase", 32'(dph), 32'd3);
        chk("add_phase_after", 32'(a0), 32'd0);
        chk("add_halt_pc", 32'(pc), 32'd1);

        // Undefined opcode 100 then HALT.
        timing_run(16'h0100, runs, pcs, dph, a0, a1, a2);
        chk("undef_done_phase", 32'(dph), 32'd1);
        chk("undef_wrap2", 32'(a0), 32'd2);
        chk("undef_wrap3", 32'(a1), 32'd3);
        chk("undef_wrap0", 32'(a2), 32'd0);
        chk("undef_halt_pc", 32'(pc), 32'd1);
        chk("undef_halted", 32'(halted), 32'd1);

`ifdef SEQ_STEP_EN
        step = 1'b0;
        do_reset();
        load(5'd0, 16'h0040); load(5'd1, 16'h0005); load(5'd2, 16'h01C0);
        pulse_start();
        repeat (16) tick();
        chk("step_pc_hold", 32'(pc), 32'd0);
        chk("step_busy", 32'(busy), 32'd1);
        load(5'd0, 16'hFFFF);
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_halt("step_halt");
        chk("step_one_instr_pc", 32'(pc), 32'd2);
        chk("step_one_instr_r0", 32'(c_r[0]), 32'd5);
        step = 1'b1;
        pulse_start();
        wait_run("step_rerun");
        chk("step_mem_kept", 32'(cpu_din), 32'h0040);
`endif

        // Randomized programs, starts and loads.
        for (int it = 0; it < 25; it++) begin
            do_reset();
            for (int a = 0; a < NW; a++) begin
                w = 16'($urandom);
                w[8:6] = 3'($urandom_range(0, 6));
                load(AW'(a), w);
            end
            if ($urandom_range(0, 3) != 0) load(AW'($urandom_range(4, 20)), 16'h01C0);
            load_en = 1'($urandom_range(0, 1));
            load_addr = AW'($urandom_range(0, NW - 1));
            load_data = 16'($urandom);
            start = 1'b1;
            tick();
            start = 1'b0;
            load_en = 1'b0;
            for (int c = 0; c < 150; c++) begin
                start = ($urandom_range(0, 7) == 0);
                load_en = ($urandom_range(0, 5) == 0);
                load_addr = AW'($urandom_range(0, NW - 1));
                load_data = 16'($urandom);
`ifdef SEQ_STEP_EN
                step = 1'($urandom_range(0, 1));
`endif
                tick();
            end
            start = 1'b0;
            load_en = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
